// File: rtl/recover_pkg.sv
// Shared types and constants for the HDB3 receive lock controller and level classifier.
package recover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HUNT    = 2'b01,
        ST_ACQUIRE = 2'b10,
        ST_LOCKED  = 2'b11
    } rc_state_e;

    localparam logic [1:0] LVL_ZERO    = 2'b00;
    localparam logic [1:0] LVL_POS     = 2'b01;
    localparam logic [1:0] LVL_NEG     = 2'b10;
    localparam logic [1:0] LVL_INVALID = 2'b11;

    localparam logic [7:0] POS_MIN  = 8'h58;
    localparam logic [7:0] ZERO_MIN = 8'h30;
    localparam logic [7:0] ZERO_MAX = 8'h3f;
    localparam logic [7:0] NEG_MAX  = 8'h0f;

endpackage

// File: rtl/hdb3_level_cls.sv
// Maps one AD sample onto a line level; samples in the guard bands come out INVALID.
module hdb3_level_cls (
    input  logic [7:0] sample,
    output logic [1:0] level
);
    import recover_pkg::*;

    always_comb begin
        level = LVL_INVALID;
        if (sample >= POS_MIN) begin
            level = LVL_POS;
        end else if (sample >= ZERO_MIN && sample <= ZERO_MAX) begin
            level = LVL_ZERO;
        end else if (sample <= NEG_MAX) begin
            level = LVL_NEG;
        end
    end

endmodule

// File: rtl/recover_ctrl.sv
// Symbol-timing recovery: edge detection on classified samples driving a
// hunt/acquire/lock machine around a phase counter, with registered outputs.
module recover_ctrl #(
    parameter int OSR          = 16,
    parameter int LOCK_EDGES   = 4,
    parameter int TOL          = 2,
    parameter int MAX_IDLE_SYM = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] indata_8,
    output logic       clk_out,
    output logic       sym_strobe,
    output logic [1:0] sym_level,
    output logic       locked,
    output logic       lol,
    output logic [1:0] state
);
    import recover_pkg::*;

    localparam int PW = $clog2(OSR);
    localparam int GW = $clog2(LOCK_EDGES + 1);
    localparam int IW = $clog2(MAX_IDLE_SYM + 2);

    localparam logic [PW-1:0] PH_ONE    = PW'(1);
    localparam logic [PW-1:0] PH_TOL    = PW'(TOL);
    localparam logic [PW-1:0] PH_EARLY  = PW'(OSR - TOL);
    localparam logic [PW-1:0] PH_HALF   = PW'(OSR / 2);
    localparam logic [PW:0]   OSR_EXT   = (PW + 1)'(OSR);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_EDGES);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(MAX_IDLE_SYM);

    logic [7:0]    sample_q, sample_d;
    logic [1:0]    prev_cls_q, prev_cls_d;
    rc_state_e     state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [GW-1:0] good_q, good_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [1:0]    bad_q, bad_d;
    logic          clk_en_q, clk_en_d;
    logic          clk_out_q, clk_out_d;
    logic          strobe_q, strobe_d;
    logic [1:0]    level_q, level_d;
    logic          locked_q, locked_d;
    logic          lol_q, lol_d;

    logic [1:0]    cls;
    logic          cls_valid;
    logic          sym_edge;
    logic          in_win;
    logic [1:0]    step;
    logic [PW:0]   phase_sum;
    logic          wrap;
    logic [PW-1:0] phase_adv;
    logic [GW-1:0] good_inc;
    logic [IW-1:0] idle_inc;
    logic [1:0]    bad_inc;

    hdb3_level_cls u_cls (
        .sample (sample_q),
        .level  (cls)
    );

    assign sample_d   = indata_8;
    assign cls_valid  = (cls != LVL_INVALID);
    assign sym_edge   = cls_valid && (cls != prev_cls_q);
    assign prev_cls_d = cls_valid ? cls : prev_cls_q;
    assign in_win     = (phase_q <= PH_TOL) || (phase_q >= PH_EARLY);

    // Phase step: 1 normally, 0 retards a late edge, 2 advances an early one.
    always_comb begin
        step = 2'd1;
        if (state_q == ST_LOCKED && sym_edge && in_win && phase_q != '0) begin
            step = (phase_q <= PH_TOL) ? 2'd0 : 2'd2;
        end
    end

    assign phase_sum = {1'b0, phase_q} + {{(PW - 1){1'b0}}, step};
    assign wrap      = (phase_sum >= OSR_EXT);
    assign phase_adv = wrap ? PW'(phase_sum - OSR_EXT) : PW'(phase_sum);

    assign good_inc = (good_q == '1) ? good_q : good_q + GW'(1);
    assign idle_inc = (idle_q == '1) ? idle_q : idle_q + IW'(1);
    assign bad_inc  = (bad_q == 2'd3) ? bad_q : bad_q + 2'd1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        good_d  = good_q;
        idle_d  = idle_q;
        bad_d   = bad_q;
        lol_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                good_d  = '0;
                idle_d  = '0;
                bad_d   = '0;
                state_d = ST_HUNT;
            end
            ST_HUNT: begin
                phase_d = '0;
                good_d  = '0;
                idle_d  = '0;
                bad_d   = '0;
                if (sym_edge) begin
                    phase_d = PH_ONE;
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                bad_d = '0;
                if (sym_edge) begin
                    phase_d = PH_ONE;
                    idle_d  = '0;
                    good_d  = in_win ? good_inc : '0;
                    if (good_d == GOOD_LOCK) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    phase_d = phase_adv;
                    if (wrap) begin
                        idle_d = idle_inc;
                    end
                    if (idle_d > IDLE_MAX) begin
                        state_d = ST_HUNT;
                        phase_d = '0;
                        good_d  = '0;
                        idle_d  = '0;
                    end
                end
            end
            default: begin
                phase_d = phase_adv;
                if (sym_edge) begin
                    idle_d = '0;
                    bad_d  = in_win ? 2'd0 : bad_inc;
                end else if (wrap) begin
                    idle_d = idle_inc;
                end
                if (bad_d == 2'd2 || idle_d > IDLE_MAX) begin
                    lol_d   = 1'b1;
                    state_d = ST_HUNT;
                    phase_d = '0;
                    good_d  = '0;
                    idle_d  = '0;
                    bad_d   = '0;
                end
            end
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            phase_d = '0;
            good_d  = '0;
            idle_d  = '0;
            bad_d   = '0;
            lol_d   = 1'b0;
        end
    end

    // clk_out stays low after lock until the first phase wrap.
    always_comb begin
        locked_d  = (state_d == ST_LOCKED);
        clk_en_d  = locked_d && (clk_en_q || (state_q == ST_LOCKED && wrap));
        clk_out_d = clk_en_d && (phase_d < PH_HALF);
        strobe_d  = locked_d && (phase_d == PH_HALF);
        level_d   = level_q;
        if (strobe_d) begin
            level_d = cls_valid ? cls : prev_cls_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sample_q   <= '0;
            prev_cls_q <= LVL_ZERO;
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            good_q     <= '0;
            idle_q     <= '0;
            bad_q      <= '0;
            clk_en_q   <= 1'b0;
            clk_out_q  <= 1'b0;
            strobe_q   <= 1'b0;
            level_q    <= LVL_ZERO;
            locked_q   <= 1'b0;
            lol_q      <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            prev_cls_q <= prev_cls_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            good_q     <= good_d;
            idle_q     <= idle_d;
            bad_q      <= bad_d;
            clk_en_q   <= clk_en_d;
            clk_out_q  <= clk_out_d;
            strobe_q   <= strobe_d;
            level_q    <= level_d;
            locked_q   <= locked_d;
            lol_q      <= lol_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign sym_strobe = strobe_q;
    assign sym_level  = level_q;
    assign locked     = locked_q;
    assign lol        = lol_q;
    assign state      = state_q;

endmodule

// File: tb/tb_recover_ctrl.sv
// Bench for recover_ctrl: randomized symbol streams compared cycle by cycle
// against a timing-error based reference model, plus directed lock/loss checks.
module tb_recover_ctrl;
    localparam int OSR          = 16;
    localparam int LOCK_EDGES   = 4;
    localparam int TOL          = 2;
    localparam int MAX_IDLE_SYM = 4;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] indata_8 = 8'h00;
    logic       clk_out, sym_strobe, locked, lol;
    logic [1:0] sym_level, state;

    always #5 clk_in = ~clk_in;

    recover_ctrl #(
        .OSR          (OSR),
        .LOCK_EDGES   (LOCK_EDGES),
        .TOL          (TOL),
        .MAX_IDLE_SYM (MAX_IDLE_SYM)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .enable     (enable),
        .indata_8   (indata_8),
        .clk_out    (clk_out),
        .sym_strobe (sym_strobe),
        .sym_level  (sym_level),
        .locked     (locked),
        .lol        (lol),
        .state      (state)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: levels 0 zero, 1 pos, 2 neg, 3 invalid;
    // states 0 idle, 1 hunt, 2 acquire, 3 locked.
    int ms_sample = 0, ms_prev = 0, ms_state = 0, ms_phase = 0;
    int ms_good = 0, ms_idle = 0, ms_bad = 0, ms_clken = 0;
    int mo_clk = 0, mo_strobe = 0, mo_level = 0, mo_locked = 0, mo_lol = 0;

    int cyc = 0, lock_cyc = -1, lol_seen = 0, lock_drops = 0, strobe_seen = 0;
    int cur_lvl = 0;
    bit prev_locked_obs = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int cls_of(input int v);
        if (v >= 88) return 1;
        if (v >= 48 && v <= 63) return 0;
        if (v <= 15) return 2;
        return 3;
    endfunction

    function automatic logic [7:0] lvl_val(input int l);
        case (l)
            1: return 8'($urandom_range(255, 88));
            0: return 8'($urandom_range(63, 48));
            2: return 8'($urandom_range(15, 0));
            default: return ($urandom_range(0, 1) == 0) ? 8'($urandom_range(47, 16))
                                                        : 8'($urandom_range(87, 64));
        endcase
    endfunction

    function automatic int pat(input int n);
        case (n % 4)
            0: return 1;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int pat_start(input int cur);
        if (cur == 0) return 0;
        if (cur == 1) return 1;
        return 3;
    endfunction

    task automatic model_tick(input logic r, input logic e, input logic [7:0] d);
        int c, err, nstate, nphase, total, corr;
        bit valid, ev, inwin, wrapped, lose;
        if (!r) begin
            ms_sample = 0; ms_prev = 0; ms_state = 0; ms_phase = 0;
            ms_good = 0; ms_idle = 0; ms_bad = 0; ms_clken = 0;
            mo_clk = 0; mo_strobe = 0; mo_level = 0; mo_locked = 0; mo_lol = 0;
            return;
        end
        c = cls_of(ms_sample);
        valid = (c != 3);
        ev = valid && (c != ms_prev);
        err = (ms_phase <= OSR / 2) ? ms_phase : ms_phase - OSR;
        inwin = (err >= -TOL) && (err <= TOL);
        nstate = ms_state; nphase = ms_phase; wrapped = 0; lose = 0;
        if (!e) begin
            nstate = 0;
        end else begin
            case (ms_state)
                0: nstate = 1;
                1: if (ev) begin nstate = 2; nphase = 1; end
                2: begin
                    if (ev) begin
                        nphase = 1;
                        ms_idle = 0;
                        ms_good = inwin ? ms_good + 1 : 0;
                        if (ms_good >= LOCK_EDGES) nstate = 3;
                    end else begin
                        nphase = (ms_phase + 1) % OSR;
                        if (nphase == 0) ms_idle++;
                        if (ms_idle > MAX_IDLE_SYM) nstate = 1;
                    end
                end
                default: begin
                    corr = 0;
                    if (ev && inwin) corr = (err > 0) ? -1 : ((err < 0) ? 1 : 0);
                    total = ms_phase + 1 + corr;
                    wrapped = (total >= OSR);
                    nphase = total % OSR;
                    if (ev) begin
                        ms_idle = 0;
                        ms_bad = inwin ? 0 : ms_bad + 1;
                    end else if (wrapped) begin
                        ms_idle++;
                    end
                    if (ms_bad >= 2 || ms_idle > MAX_IDLE_SYM) begin
                        lose = 1;
                        nstate = 1;
                    end
                end
            endcase
        end
        if (nstate <= 1) begin
            nphase = 0; ms_good = 0; ms_idle = 0; ms_bad = 0;
        end
        if (nstate != 3) ms_clken = 0;
        else if (ms_state == 3 && wrapped) ms_clken = 1;
        mo_locked = (nstate == 3);
        mo_clk = (ms_clken != 0 && nphase < OSR / 2);
        mo_strobe = (nstate == 3 && nphase == OSR / 2);
        if (mo_strobe != 0) mo_level = valid ? c : ms_prev;
        mo_lol = lose;
        if (valid) ms_prev = c;
        ms_state = nstate;
        ms_phase = nphase;
        ms_sample = d;
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] d);
        rst_n = r;
        enable = e;
        indata_8 = d;
        @(posedge clk_in);
        model_tick(r, e, d);
        #1;
        cyc++;
        check("state", state, ms_state);
        check("locked", locked, mo_locked);
        check("clk_out", clk_out, mo_clk);
        check("sym_strobe", sym_strobe, mo_strobe);
        check("sym_level", sym_level, mo_level);
        check("lol", lol, mo_lol);
        if (lol) lol_seen++;
        if (sym_strobe) strobe_seen++;
        if (prev_locked_obs && !locked) lock_drops++;
        if (!prev_locked_obs && locked && lock_cyc < 0) lock_cyc = cyc;
        prev_locked_obs = locked;
    endtask

    task automatic send_sym(input int l, input int period, input bit inj);
        logic [7:0] v;
        for (int i = 0; i < period; i++) begin
            v = lvl_val(l);
            if (inj && i >= 4 && i < period - 4 && $urandom_range(0, 2) == 0) v = lvl_val(3);
            step(1'b1, 1'b1, v);
        end
        cur_lvl = l;
    endtask

    initial begin
        int start_cyc, k, nl, run;
        bit reached;

        // Reset with random enable and data.
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        check("rst_state", state, 0);
        check("rst_clk_out", clk_out, 0);
        check("rst_strobe", sym_strobe, 0);
        check("rst_level", sym_level, 0);
        check("rst_locked", locked, 0);
        check("rst_lol", lol, 0);

        // Clean lock with ideal +1,0,-1,0 symbols.
        lock_cyc = -1;
        start_cyc = cyc;
        for (int n = 0; n < 12; n++) begin
            if (n == 8) strobe_seen = 0;
            send_sym(pat(n), OSR, 1'b0);
        end
        check("clean_lock_latency", (lock_cyc >= 0) ? lock_cyc - start_cyc : -1,
              2 + OSR * LOCK_EDGES);
        check("clean_strobe_count", strobe_seen, 4);

        // Random symbols at nominal rate, never more than two identical in a row.
        lol_seen = 0;
        lock_drops = 0;
        run = 0;
        for (int s = 0; s < 30; s++) begin
            nl = $urandom_range(0, 2);
            if (nl == cur_lvl) begin
                run++;
                if (run >= 2) begin
                    nl = (nl + 1 + $urandom_range(0, 1)) % 3;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            send_sym(nl, OSR, 1'b0);
        end
        check("random_lock_drops", lock_drops, 0);
        check("random_lol", lol_seen, 0);

        // Drift: slow symbols then fast symbols.
        k = pat_start(cur_lvl);
        for (int n = 0; n < 12; n++) send_sym(pat(k + n), OSR + 1, 1'b0);
        for (int n = 12; n < 24; n++) send_sym(pat(k + n), OSR - 1, 1'b0);
        check("drift_lock_drops", lock_drops, 0);
        check("drift_lol", lol_seen, 0);
        check("drift_locked", locked, 1);

        // Guard-band samples injected mid-symbol.
        k = pat_start(cur_lvl);
        for (int n = 0; n < 16; n++) send_sym(pat(k + n), OSR, 1'b1);
        check("invalid_lock_drops", lock_drops, 0);
        check("invalid_locked", locked, 1);

        // Lost signal: hold zero level.
        lol_seen = 0;
        for (int i = 0; i < 6 * OSR; i++) step(1'b1, 1'b1, 8'h38);
        cur_lvl = 0;
        check("lost_lol_pulses", lol_seen, 1);
        check("lost_state", state, 1);
        check("lost_clk_out", clk_out, 0);
        check("lost_locked", locked, 0);

        // Relock, then drop enable while locked.
        for (int n = 0; n < 10; n++) send_sym(pat(n), OSR, 1'b0);
        check("relock_locked", locked, 1);
        lol_seen = 0;
        step(1'b1, 1'b0, lvl_val(pat(10)));
        check("en_drop_state", state, 0);
        check("en_drop_lol", lol, 0);
        check("en_drop_locked", locked, 0);

        // Walk into ACQUIRE, then reset.
        reached = 1'b0;
        for (int c = 0; c < OSR * 8 && !reached; c++) begin
            step(1'b1, 1'b1, lvl_val(pat(11 + c / OSR)));
            if (ms_state == 2) reached = 1'b1;
        end
        check("acquire_reached", reached, 1);
        step(1'b0, 1'b1, 8'($urandom));
        check("acq_rst_state", state, 0);
        check("acq_rst_lol", lol, 0);
        check("acq_rst_clk_out", clk_out, 0);
        check("no_lol_on_exits", lol_seen, 0);

        // Relock after reset must match the clean-lock latency.
        lock_cyc = -1;
        start_cyc = cyc;
        for (int n = 0; n < 8; n++) send_sym(pat(n), OSR, 1'b0);
        check("relock_latency", (lock_cyc >= 0) ? lock_cyc - start_cyc : -1,
              2 + OSR * LOCK_EDGES);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/recover_ctrl.md
# recover_ctrl

Lock controller for the HDB3 receive front end. It classifies each 8-bit AD sample into a line level, finds symbol edges, and runs a hunt/acquire/lock state machine around a phase counter. Outputs are a recovered symbol clock, a mid-symbol sample strobe with the classified level, and lock status. It sits between the AD interface and the HDB3 decoder, and it gates the decoder so that the decoder only sees symbols while lock is held.

## Interface
Parameters:
- OSR, 16: clk_in cycles per symbol; even, ≥ 8
- LOCK_EDGES, 4: consecutive in-window edges needed to declare lock
- TOL, 2: phase window, ±TOL cycles around phase 0
- MAX_IDLE_SYM, 4: allowed symbols without an edge (HDB3 bounds zero runs to 3)

Ports:
- clk_in  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- enable  in  1  run controller; 0 forces IDLE
- indata_8  in  8  raw AD sample, one per clk_in
- clk_out  out  1  recovered symbol clock, 50% duty
- sym_strobe  out  1  one-cycle pulse at mid-symbol
- sym_level  out  2  level captured at strobe: 00 zero, 01 pos, 10 neg
- locked  out  1  high in LOCKED
- lol  out  1  one-cycle pulse on loss of lock
- state  out  2  00 IDLE, 01 HUNT, 10 ACQUIRE, 11 LOCKED

## Operation
- Sample path:
  - indata_8 registers into sample_q.
  - Classification of sample_q: ≥ 8'h58 → POS; 8'h30..8'h3f → ZERO; ≤ 8'h0f → NEG; anything else → INVALID.
  - INVALID does not update prev_cls and never produces an edge.
- Edge: valid class ≠ prev_cls. prev_cls updates on every valid class. prev_cls resets to ZERO.
- phase: counts 0..OSR-1 and wraps. Phase 0 is the symbol boundary.
- idle_sym: increments on each wrap that had no edge in the symbol; clears on any edge.
- States:
  - IDLE: phase, good_cnt, idle_sym and bad_cnt all 0. Leaves for HUNT when enable=1.
  - HUNT: phase frozen at 0. The first edge sets phase←1, good_cnt←0, then → ACQUIRE.
  - ACQUIRE: every edge hard-aligns phase←1.
    - In-window edge (phase ≤ TOL or phase ≥ OSR-TOL): good_cnt+1.
    - Out-of-window edge: good_cnt←0.
    - good_cnt reaching LOCK_EDGES → LOCKED.
    - idle_sym > MAX_IDLE_SYM → HUNT.
  - LOCKED:
    - Edge at phase 0: normal count.
    - Edge at phase 1..TOL: phase holds for one cycle (retard by 1).
    - Edge at phase OSR-TOL..OSR-1: phase←(phase+2) mod OSR (advance by 1).
    - In-window edge clears bad_cnt. Out-of-window edge: bad_cnt+1, no correction.
    - bad_cnt = 2 or idle_sym > MAX_IDLE_SYM → lol pulse, then → HUNT.
- enable=0 in any state → IDLE on the next cycle. No lol pulse for this exit.
- Outputs when not LOCKED: clk_out=0, sym_strobe=0, sym_level held.
- In LOCKED:
  - clk_out=1 for phase < OSR/2.
  - sym_strobe fires when phase == OSR/2, and sym_level loads the current valid class at that strobe. If the sample is INVALID, sym_level takes prev_cls.

## Timing
- Reset (rst_n=0 at a clk_in edge) gives: state IDLE, clk_out 0, sym_strobe 0, sym_level 00, locked 0, lol 0, sample_q 0, all counters 0.
- Reset mid-operation takes priority over enable and all state logic.
- An input transition presented before edge k registers at k and acts on state/phase at edge k+1.
- All outputs are registered. locked rises on the cycle state becomes LOCKED.
- First clk_out rise follows the phase wrap after lock.
- Simultaneous events:
  - Edge on the same cycle as a wrap: counts as an edge; idle_sym clears.
  - Edge and enable=0 on the same cycle: enable wins.
  - lol and a new edge on the same cycle: go to HUNT; the edge is not reused.
- Counter widths: phase is $clog2(OSR). good_cnt, idle_sym and bad_cnt are saturating.

## Structure
- recover_pkg holds:
  - state enum
  - level codes (ZERO/POS/NEG/INVALID)
  - threshold constants: POS_MIN 8'h58, ZERO_MIN 8'h30, ZERO_MAX 8'h3f, NEG_MAX 8'h0f
- Sub-module hdb3_level_cls: combinational sample→class mapping, reused by the decoder.
- Everything else (state machine, phase counter, edge logic) lives in one module.

## Test plan
- Reset: drive rst_n=0 for 3 cycles with random indata_8 → all outputs 0, state 00.
- Clean lock: OSR=16, ideal symbols +1,0,−1,0 repeating (8'hff, 8'h38, 8'h00) → HUNT at first edge, ACQUIRE, locked after the 5th edge; sym_strobe every 16 cycles at phase 8 with the correct levels.
- Drift: symbol period 17 cycles, then 15 → locked stays 1, one phase correction per edge, lol never fires.
- Lost signal: after lock, hold 8'h38 for 6 symbols → lol pulse once, state HUNT, clk_out 0.
- Invalid band: inject 8'h20 and 8'h48 between valid levels → no spurious edges, lock maintained, sym_level unaffected.
- enable drop mid-LOCKED, then sync reset mid-ACQUIRE → IDLE next cycle with no lol pulse; after reset, relock matches the clean-lock timing.
